// File: rtl/lfsr_prbs_pkg.sv
`default_nettype none
//==============================================================================
// Module      : lfsr_prbs_pkg
// Description : Shared constants and helpers for the PRBS checker.
// Revision    : 1.0 - initial release
//==============================================================================
package lfsr_prbs_pkg;

    localparam logic [1:0] c_search = 2'd0;
    localparam logic [1:0] c_verify = 2'd1;
    localparam logic [1:0] c_locked = 2'd2;

    // Words needed before the history register holds only received bits.
    function automatic int fill_words(input int lfsr_width, input int data_width);
        return (lfsr_width + data_width - 1) / data_width;
    endfunction

    // Caller zero-extends its vector; only the low 'width' bits are counted.
    function automatic logic [8:0] popcount(input logic [255:0] vec, input int width);
        logic [8:0] cnt;
        cnt = '0;
        for (int i = 0; i < 256; i++) begin
            if (i < width) cnt = cnt + 9'(vec[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_prbs_check_lfsr.sv
`default_nettype none
//==============================================================================
// Module      : lfsr_prbs_check_lfsr
// Description : Combinational LFSR next-state / output-word block.
// Revision    : 1.0 - initial release
//==============================================================================
module lfsr_prbs_check_lfsr #(
    parameter int                    LFSR_WIDTH  = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b0,
    parameter int                    DATA_WIDTH  = 8,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    // Bit-serial reference: MSB of the word is the first bit through the register.
    function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] step(
        input logic [LFSR_WIDTH-1:0] s_in,
        input logic [DATA_WIDTH-1:0] d_in
    );
        logic [LFSR_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] o;
        logic                  fb;
        if (REVERSE) begin
            s = {<<{s_in}};
            d = {<<{d_in}};
        end else begin
            s = s_in;
            d = d_in;
        end
        o = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = s[LFSR_WIDTH-1] ^ d[i];
            if (LFSR_CONFIG == "GALOIS") begin
                s = {s[LFSR_WIDTH-2:0], fb} ^ ({LFSR_POLY[LFSR_WIDTH-1:1], 1'b0} & {LFSR_WIDTH{fb}});
            end else begin
                for (int j = 1; j < LFSR_WIDTH; j++) begin
                    if (LFSR_POLY[j]) fb = fb ^ s[j-1];
                end
                s = {s[LFSR_WIDTH-2:0], fb};
            end
            o[i] = fb;
        end
        if (REVERSE) begin
            s = {<<{s}};
            o = {<<{o}};
        end
        return {s, o};
    endfunction

    logic [LFSR_WIDTH+DATA_WIDTH-1:0] w_result;

    generate
        if (STYLE == "REDUCTION") begin : g_reduction
            // The map is linear, so XOR together the response of every input bit.
            always_comb begin
                w_result = '0;
                for (int j = 0; j < LFSR_WIDTH; j++) begin
                    if (state_in[j]) w_result = w_result ^ step(LFSR_WIDTH'(1) << j, '0);
                end
                for (int j = 0; j < DATA_WIDTH; j++) begin
                    if (data_in[j]) w_result = w_result ^ step('0, DATA_WIDTH'(1) << j);
                end
            end
        end else begin : g_loop
            always_comb w_result = step(state_in, data_in);
        end
    endgenerate

    assign {state_out, data_out} = w_result;

endmodule
`default_nettype wire

// File: rtl/lfsr_prbs_check.sv
`default_nettype none
//==============================================================================
// Module      : lfsr_prbs_check
// Description : Self-synchronising parallel PRBS checker with error counters.
// Revision    : 1.0 - initial release
//==============================================================================
module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter bit                    REVERSE      = 1'b0,
    parameter int                    DATA_WIDTH   = 8,
    parameter string                 STYLE        = "AUTO",
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  resync,
    input  logic                  clear_counts,
    output logic                  locked,
    output logic [DATA_WIDTH-1:0] error_bits,
    output logic                  error_valid,
    output logic [CNT_WIDTH-1:0]  err_bit_count,
    output logic [CNT_WIDTH-1:0]  err_word_count
);
    import lfsr_prbs_pkg::*;

    localparam int c_fill_words = fill_words(LFSR_WIDTH, DATA_WIDTH);
    localparam int c_fill_w     = $clog2(c_fill_words + 1);
    localparam int c_run_w      = $clog2(LOCK_COUNT + 1);
    localparam int c_bad_w      = $clog2(UNLOCK_COUNT + 1);
    localparam int c_sum_w      = CNT_WIDTH + 10;

    logic [1:0]            r_state, w_state_nxt;
    logic [LFSR_WIDTH-1:0] r_history, w_history_nxt;
    logic [c_fill_w-1:0]   r_fill_cnt, w_fill_nxt;
    logic [c_run_w-1:0]    r_run_cnt, w_run_nxt;
    logic [c_bad_w-1:0]    r_bad_cnt, w_bad_nxt;
    logic                  r_locked;
    logic [DATA_WIDTH-1:0] r_error_bits, w_error_bits_nxt;
    logic                  r_error_valid, w_error_valid_nxt;
    logic [CNT_WIDTH-1:0]  r_err_bit_count, w_bit_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_err_word_count, w_word_cnt_nxt;

    logic [DATA_WIDTH-1:0] w_predicted;
    logic [LFSR_WIDTH-1:0] w_lfsr_state;
    logic [LFSR_WIDTH-1:0] w_shift_history;
    logic [DATA_WIDTH-1:0] w_mismatch;
    logic                  w_word_bad;

    lfsr_prbs_check_lfsr #(
        .LFSR_WIDTH  (LFSR_WIDTH),
        .LFSR_POLY   (LFSR_POLY),
        .LFSR_CONFIG ("FIBONACCI"),
        .REVERSE     (REVERSE),
        .DATA_WIDTH  (DATA_WIDTH),
        .STYLE       (STYLE)
    ) u_lfsr (
        .data_in   ('0),
        .state_in  (r_history),
        .data_out  (w_predicted),
        .state_out (w_lfsr_state)
    );

    // Self-synchronising history load: received word shifted into the register.
    generate
        if (REVERSE) begin : g_hist_lsb_first
            assign w_shift_history = LFSR_WIDTH'({data_in, r_history} >> DATA_WIDTH);
        end else begin : g_hist_msb_first
            assign w_shift_history = LFSR_WIDTH'({r_history, data_in});
        end
    endgenerate

    assign w_mismatch = data_in ^ w_predicted;
    assign w_word_bad = (w_mismatch != '0);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [8:0]           b);
        logic [c_sum_w-1:0] sum;
        sum = c_sum_w'(a) + c_sum_w'(b);
        if (sum > c_sum_w'({CNT_WIDTH{1'b1}})) return '1;
        return sum[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_state_nxt       = r_state;
        w_history_nxt     = r_history;
        w_fill_nxt        = r_fill_cnt;
        w_run_nxt         = r_run_cnt;
        w_bad_nxt         = r_bad_cnt;
        w_error_valid_nxt = 1'b0;
        w_error_bits_nxt  = r_error_bits;
        w_bit_cnt_nxt     = clear_counts ? '0 : r_err_bit_count;
        w_word_cnt_nxt    = clear_counts ? '0 : r_err_word_count;

        if (resync) begin
            w_state_nxt   = c_search;
            w_history_nxt = '0;
            w_fill_nxt    = '0;
            w_run_nxt     = '0;
            w_bad_nxt     = '0;
        end else if (data_valid) begin
            // Once locked the history free-runs on its own prediction.
            w_history_nxt = (r_state == c_locked) ? w_lfsr_state : w_shift_history;
            case (r_state)
                c_search: begin
                    w_fill_nxt = r_fill_cnt + 1'b1;
                    if (w_fill_nxt == c_fill_w'(c_fill_words)) begin
                        w_state_nxt = c_verify;
                        w_run_nxt   = '0;
                    end
                end
                c_verify: begin
                    if (w_word_bad || (r_history == '0)) begin
                        w_run_nxt = '0;
                    end else begin
                        w_run_nxt = r_run_cnt + 1'b1;
                        if (w_run_nxt == c_run_w'(LOCK_COUNT)) begin
                            w_state_nxt = c_locked;
                            w_bad_nxt   = '0;
                        end
                    end
                end
                c_locked: begin
                    w_error_valid_nxt = 1'b1;
                    w_error_bits_nxt  = w_mismatch;
                    w_bit_cnt_nxt     = sat_add(w_bit_cnt_nxt, popcount(256'(w_mismatch), DATA_WIDTH));
                    if (w_word_bad) begin
                        w_word_cnt_nxt = sat_add(w_word_cnt_nxt, 9'd1);
                        w_bad_nxt      = r_bad_cnt + 1'b1;
                        if (w_bad_nxt == c_bad_w'(UNLOCK_COUNT)) begin
                            w_state_nxt = c_search;
                            w_fill_nxt  = '0;
                        end
                    end else begin
                        w_bad_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_search;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_search;
            r_history        <= '0;
            r_fill_cnt       <= '0;
            r_run_cnt        <= '0;
            r_bad_cnt        <= '0;
            r_locked         <= 1'b0;
            r_error_bits     <= '0;
            r_error_valid    <= 1'b0;
            r_err_bit_count  <= '0;
            r_err_word_count <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_history        <= w_history_nxt;
            r_fill_cnt       <= w_fill_nxt;
            r_run_cnt        <= w_run_nxt;
            r_bad_cnt        <= w_bad_nxt;
            r_locked         <= (w_state_nxt == c_locked);
            r_error_bits     <= w_error_bits_nxt;
            r_error_valid    <= w_error_valid_nxt;
            r_err_bit_count  <= w_bit_cnt_nxt;
            r_err_word_count <= w_word_cnt_nxt;
        end
    end

    assign locked         = r_locked;
    assign error_bits     = r_error_bits;
    assign error_valid    = r_error_valid;
    assign err_bit_count  = r_err_bit_count;
    assign err_word_count = r_err_word_count;

endmodule
`default_nettype wire
